// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank: default sizing,
// the mp4 event channel map and the read-response record.
package perf_pkg;

  localparam int unsigned NUM_CH_DEF = 12;
  localparam int unsigned CNT_W_DEF  = 32;
  localparam int unsigned MAX_CNT_W  = 64;

  localparam int unsigned CH_CYCLES     = 0;
  localparam int unsigned CH_PMEM_RESP  = 1;
  localparam int unsigned CH_L1I_SERVE  = 2;
  localparam int unsigned CH_L1I_MISS   = 3;
  localparam int unsigned CH_L1D_SERVE  = 4;
  localparam int unsigned CH_L1D_MISS   = 5;
  localparam int unsigned CH_L2_SERVE   = 6;
  localparam int unsigned CH_L2_MISS    = 7;
  localparam int unsigned CH_DATA_STALL = 8;
  localparam int unsigned CH_MEM_STALL  = 9;

  // data is sized for the widest legal counter; narrower banks zero-extend
  typedef struct packed {
    logic [MAX_CNT_W-1:0] data;
    logic                 ovf;
    logic                 err;
  } rd_resp_t;

endpackage

// File: rtl/perf_counter.sv
// One event channel: live counter with sticky overflow flag and a
// snapshot shadow copy that the read port sees.
module perf_counter
  import perf_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt,
  input  logic             en,
  input  logic             clear,
  input  logic             snap,
  output logic             ovf_nxt,
  output logic [CNT_W-1:0] shadow,
  output logic             shadow_ovf
);

  logic [CNT_W-1:0] cnt_r;
  logic             ovf_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] shadow_r;
  logic             shadow_ovf_r;

  // next live count: clear beats events, overflow wraps or holds
  always_comb begin
    cnt_nxt_s = cnt_r;
    ovf_nxt   = ovf_r;
    if (clear) begin
      cnt_nxt_s = {CNT_W{1'b0}};
      ovf_nxt   = 1'b0;
    end else if (evt && en) begin
      if (cnt_r == {CNT_W{1'b1}}) begin
        ovf_nxt = 1'b1;
        if (SATURATE) begin
          cnt_nxt_s = cnt_r;
        end else begin
          cnt_nxt_s = {CNT_W{1'b0}};
        end
      end else begin
        cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_nxt_s = cnt_r;
      ovf_nxt   = ovf_r;
    end
  end

  // live counter and sticky overflow state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
      ovf_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      ovf_r <= ovf_nxt;
    end
  end

  // shadow captures pre-update live values so a snapshot excludes this cycle's event
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_r     <= {CNT_W{1'b0}};
      shadow_ovf_r <= 1'b0;
    end else if (snap) begin
      shadow_r     <= cnt_r;
      shadow_ovf_r <= ovf_r;
    end
  end

  assign shadow     = shadow_r;
  assign shadow_ovf = shadow_ovf_r;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters with atomic snapshot, a registered
// one-cycle read port over the shadow copies, and a live overflow summary.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int unsigned  NUM_CH   = NUM_CH_DEF,
  parameter int unsigned  CNT_W    = CNT_W_DEF,
  parameter bit           SATURATE = 1'b0,
  localparam int unsigned IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] event_i,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              clear,
  input  logic              snap,
  input  logic              rd_req,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_resp,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_ovf,
  output logic              rd_err,
  output logic              ovf_any
);

  logic [NUM_CH-1:0] ovf_nxt_s;
  logic [NUM_CH-1:0] shadow_ovf_s;
  logic [CNT_W-1:0]  shadow_s [NUM_CH];
  rd_resp_t          resp_nxt_s;
  rd_resp_t          resp_r;
  logic              rd_resp_r;
  logic              ovf_any_r;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    perf_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .evt        (event_i[g]),
      .en         (ch_en[g]),
      .clear      (clear),
      .snap       (snap),
      .ovf_nxt    (ovf_nxt_s[g]),
      .shadow     (shadow_s[g]),
      .shadow_ovf (shadow_ovf_s[g])
    );
  end

  // shadow read mux; an index with no matching channel reports an error
  always_comb begin
    resp_nxt_s = '{data: {MAX_CNT_W{1'b0}}, ovf: 1'b0, err: 1'b1};
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        resp_nxt_s.data = MAX_CNT_W'(shadow_s[i]);
        resp_nxt_s.ovf  = shadow_ovf_s[i];
        resp_nxt_s.err  = 1'b0;
      end else begin
        resp_nxt_s = resp_nxt_s;
      end
    end
  end

  // registered read response; payload holds between responses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_resp_r <= 1'b0;
      resp_r    <= '{data: {MAX_CNT_W{1'b0}}, ovf: 1'b0, err: 1'b0};
    end else begin
      rd_resp_r <= rd_req;
      if (rd_req) begin
        resp_r <= resp_nxt_s;
      end
    end
  end

  // overflow summary from next-state flags so it tracks the live flags edge for edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_any_r <= 1'b0;
    end else begin
      ovf_any_r <= |ovf_nxt_s;
    end
  end

  if (CNT_W < MAX_CNT_W) begin : g_pad
    logic rd_pad_unused_s;
    assign rd_pad_unused_s = |resp_r.data[MAX_CNT_W-1:CNT_W];
  end

  assign rd_resp = rd_resp_r;
  assign rd_data = resp_r.data[CNT_W-1:0];
  assign rd_ovf  = resp_r.ovf;
  assign rd_err  = resp_r.err;
  assign ovf_any = ovf_any_r;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench: a wrap-mode and a saturate-mode 8-bit bank share stimulus;
// expected read responses are queued at request time and checked on response.
module tb_perf_counter_bank;

  localparam int NUM_CH = 12;
  localparam int CNT_W  = 8;
  localparam int IDX_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] event_i;
  logic [NUM_CH-1:0] ch_en;
  logic              clear, snap, rd_req;
  logic [IDX_W-1:0]  rd_idx;
  logic              w_resp, w_ovf, w_err, w_any;
  logic              s_resp, s_ovf, s_err, s_any;
  logic [CNT_W-1:0]  w_data, s_data;

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .event_i(event_i), .ch_en(ch_en), .clear(clear),
    .snap(snap), .rd_req(rd_req), .rd_idx(rd_idx), .rd_resp(w_resp),
    .rd_data(w_data), .rd_ovf(w_ovf), .rd_err(w_err), .ovf_any(w_any));

  perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .event_i(event_i), .ch_en(ch_en), .clear(clear),
    .snap(snap), .rd_req(rd_req), .rd_idx(rd_idx), .rd_resp(s_resp),
    .rd_data(s_data), .rd_ovf(s_ovf), .rd_err(s_err), .ovf_any(s_any));

  typedef struct {
    logic [7:0] wd;
    logic       wo;
    logic [7:0] sd;
    logic       so;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_snap();
    snap = 1'b1;
    step();
    snap = 1'b0;
  endtask

  task automatic run_events(input int ch, input int n);
    event_i = '0;
    event_i[ch] = 1'b1;
    repeat (n) step();
    event_i = '0;
  endtask

  task automatic check_resp();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_empty: observed response with no queued expectation");
    end else begin
      e = sb_q.pop_front();
      last_e = e;
      chk("w_resp", 64'(w_resp), 64'd1);
      chk("w_data", 64'(w_data), 64'(e.wd));
      chk("w_ovf",  64'(w_ovf),  64'(e.wo));
      chk("w_err",  64'(w_err),  64'(e.err));
      chk("s_resp", 64'(s_resp), 64'd1);
      chk("s_data", 64'(s_data), 64'(e.sd));
      chk("s_ovf",  64'(s_ovf),  64'(e.so));
      chk("s_err",  64'(s_err),  64'(e.err));
    end
  endtask

  // one read request cycle; consecutive calls are back-to-back reads
  task automatic read(input int idx, input logic [7:0] wd, input logic wo,
                      input logic [7:0] sd, input logic so, input logic err);
    rd_req = 1'b1;
    rd_idx = IDX_W'(idx);
    sb_q.push_back('{wd: wd, wo: wo, sd: sd, so: so, err: err});
    step();
    check_resp();
  endtask

  task automatic end_read();
    rd_req = 1'b0;
    step();
    chk("w_resp_idle", 64'(w_resp), 64'd0);
    chk("s_resp_idle", 64'(s_resp), 64'd0);
    chk("w_data_hold", 64'(w_data), 64'(last_e.wd));
    chk("s_data_hold", 64'(s_data), 64'(last_e.sd));
  endtask

  initial begin
    rst = 1'b1; event_i = '0; ch_en = '1; clear = 1'b0; snap = 1'b0;
    rd_req = 1'b0; rd_idx = '0;
    last_e = '{wd: 8'd0, wo: 1'b0, sd: 8'd0, so: 1'b0, err: 1'b0};
    #2 rst = 1'b0;
    #10;
    chk("rst_w_resp", 64'(w_resp), 64'd0);
    chk("rst_w_data", 64'(w_data), 64'd0);
    chk("rst_w_err",  64'(w_err),  64'd0);
    chk("rst_w_any",  64'(w_any),  64'd0);
    chk("rst_s_data", 64'(s_data), 64'd0);
    chk("rst_s_ovf",  64'(s_ovf),  64'd0);
    step();
    rst = 1'b1;
    step();
    chk("idle_resp", 64'(w_resp), 64'd0);

    // basic count
    run_events(0, 10);
    pulse_snap();
    read(0, 8'd10, 1'b0, 8'd10, 1'b0, 1'b0);
    end_read();

    // overflow boundary on channel 3
    run_events(3, 255);
    chk("w_any_255", 64'(w_any), 64'd0);
    chk("s_any_255", 64'(s_any), 64'd0);
    run_events(3, 2);
    chk("w_any_257", 64'(w_any), 64'd1);
    chk("s_any_257", 64'(s_any), 64'd1);
    pulse_snap();
    read(3, 8'd1, 1'b1, 8'd255, 1'b1, 1'b0);
    end_read();
    run_events(3, 43);
    pulse_snap();
    read(3, 8'd44, 1'b1, 8'd255, 1'b1, 1'b0);
    end_read();

    // snap + clear + event together, with a read landing on the snap edge
    run_events(2, 5);
    snap = 1'b1; clear = 1'b1; event_i = 12'h004;
    read(2, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    snap = 1'b0; clear = 1'b0; event_i = '0;
    chk("w_any_clr", 64'(w_any), 64'd0);
    chk("s_any_clr", 64'(s_any), 64'd0);
    end_read();
    read(2, 8'd5, 1'b0, 8'd5, 1'b0, 1'b0);
    read(3, 8'd44, 1'b1, 8'd255, 1'b1, 1'b0);
    end_read();
    pulse_snap();
    read(2, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    read(3, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    read(0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    end_read();

    // disabled channel and index range
    ch_en = 12'hFFD;
    run_events(1, 20);
    ch_en = '1;
    pulse_snap();
    read(1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    read(13, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    read(12, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    read(11, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    end_read();

    // async reset with a read in flight
    run_events(0, 3);
    pulse_snap();
    read(0, 8'd3, 1'b0, 8'd3, 1'b0, 1'b0);
    end_read();
    rd_req = 1'b1;
    rd_idx = '0;
    #2 rst = 1'b0;
    #1;
    chk("arst_w_resp", 64'(w_resp), 64'd0);
    chk("arst_w_data", 64'(w_data), 64'd0);
    chk("arst_s_data", 64'(s_data), 64'd0);
    step();
    rd_req = 1'b0;
    chk("arst_resp_edge", 64'(w_resp), 64'd0);
    step();
    rst = 1'b1;
    step();
    chk("arst_resp_rel", 64'(w_resp), 64'd0);
    pulse_snap();
    read(0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    read(3, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    end_read();

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Synthesizable, parametrised bank of event counters that replaces the simulation-only cycle, miss, serve and stall tallies in the mp4 bench with hardware. It counts NUM_CH single-bit event strobes, such as cache serve/miss, pmem_resp and pipeline stall signals. The bank supports per-channel enable, wrap or saturate overflow modes, an atomic snapshot, and a one-cycle-latency read port. It sits beside the datapath and cache_top in mp4, and its event inputs are wired from those blocks.

## Interface
- NUM_CH, 12: number of counter channels, 1..32.
- CNT_W, 32: counter width in bits, 8..64.
- SATURATE, 0: 0 = wrap on overflow; 1 = hold at all-ones on overflow.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset. Assertion clears all state immediately. Deassertion is synchronous to clk upstream.
- event_i  in  NUM_CH  per-channel event strobe; bit i is counted once per cycle while high.
- ch_en  in  NUM_CH  per-channel count enable. It is sampled in the same cycle as event_i.
- clear  in  1  synchronous clear of all live counters and overflow flags.
- snap  in  1  copies all live counters and overflow flags into the shadow registers.
- rd_req  in  1  read request strobe.
- rd_idx  in  $clog2(NUM_CH) (min 1)  channel to read, taken from the shadow registers.
- rd_resp  out  1  read response, one cycle wide.
- rd_data  out  CNT_W  shadow counter value.
- rd_ovf  out  1  shadow overflow flag of the selected channel.
- rd_err  out  1  asserted when rd_idx >= NUM_CH.
- ovf_any  out  1  OR of all live overflow flags.

## Operation
- **Increment rule.** Live count[i] increments by 1 in a cycle where event_i[i] && ch_en[i] && !clear.
- **Overflow, wrap mode (SATURATE=0).** At all-ones, the next increment sets count to 0 and sets ovf[i]. ovf[i] is sticky.
- **Overflow, saturate mode (SATURATE=1).** At all-ones, count holds and ovf[i] is set.
- **Clear.** clear zeroes every count[i] and ovf[i] on the next edge. clear wins over a same-cycle event, and that event is dropped.
- **Snapshot.** snap copies all live counts and ovf flags into shadow[i] and shadow_ovf[i] in one edge.
  - The copy uses pre-update values, i.e. this cycle's events are excluded.
  - snap and clear in the same cycle: shadow gets the pre-clear values, and the live counters are zeroed. This is the defined snapshot-and-reset idiom.
- **Read port.**
  - Reads access the shadow registers only, so reads never tear against live counting.
  - A rd_req that coincides with snap returns the old shadow value, because the read is registered from pre-edge shadow contents.
  - Back-to-back rd_req on consecutive cycles is legal. Each request produces its own rd_resp.
- **Invalid index.** rd_idx >= NUM_CH gives rd_data=0, rd_ovf=0 and rd_err=1 with the response.
- **Disabled channels.** A channel with ch_en low holds its value. clear and snap still apply to it.

## Timing
- **Reset values.** All live counts, shadows and flags are 0. rd_resp=0, rd_data=0, rd_ovf=0, rd_err=0, ovf_any=0.
- **Count latency.** An event in cycle t is visible in live count at t+1. It is visible via the read port only after a snap at or after t+1.
- **Read latency.** rd_req in cycle t gives rd_resp=1 in cycle t+1, with rd_data, rd_ovf and rd_err valid in that same cycle.
  - rd_resp is low in every cycle without a preceding rd_req.
  - rd_data, rd_ovf and rd_err hold their last value when rd_resp=0.
- **ovf_any.** Registered from live flags: a flag set at edge t+1 is visible at t+1.
- **Reset mid-operation.** rst low asynchronously zeroes everything, including any in-flight read. No rd_resp is produced for a rd_req issued in the reset cycle.
- **Throughput.** One increment per channel per cycle, with all channels updated in parallel.

## Structure
- Shared package perf_pkg holds:
  - the default CNT_W and NUM_CH;
  - a channel index map as localparams (e.g. CH_CYCLES=0, CH_PMEM_RESP=1, CH_L1I_SERVE=2, CH_L1I_MISS=3, CH_L1D_SERVE=4, CH_L1D_MISS=5, CH_L2_SERVE=6, CH_L2_MISS=7, CH_DATA_STALL=8, CH_MEM_STALL=9);
  - a struct type for the read response {data, ovf, err}.
- One sub-module, perf_counter: a single channel with its live count, ovf flag, shadow and shadow_ovf. It takes event, en, clear and snap, and has a SATURATE parameter.
- perf_counter_bank instantiates NUM_CH perf_counter in a generate loop, plus the registered read mux and the ovf_any OR.

## Test plan
- **Reset and basic count.** Hold rst low, then release; drive event_i[0]=1 with ch_en all-ones for 10 cycles; snap; read idx 0. Expected: rd_resp one cycle after rd_req, rd_data=10, rd_ovf=0, rd_err=0.
- **Wrap overflow.** CNT_W=8, SATURATE=0. Drive 257 events on channel 3, then snap and read. Expected: rd_data=1, rd_ovf=1, ovf_any=1.
- **Saturate overflow.** CNT_W=8, SATURATE=1. Drive 300 events on channel 3, then snap and read. Expected: rd_data=255, rd_ovf=1.
- **Simultaneous snap, clear and event.**
  - Count 5 on channel 2, then assert snap+clear+event_i[2] in one cycle.
  - Expected: a shadow read returns 5.
  - Then snap again with no events; expected: a read returns 0.
- **Disable and invalid index.**
  - ch_en[1]=0 while event_i[1]=1 for 20 cycles, then snap and read idx 1. Expected: 0.
  - With NUM_CH=12, read rd_idx=13. Expected: rd_err=1, rd_data=0.
- **Async reset mid-read.** Issue rd_req, then pull rst low before the next edge. Expected: rd_resp stays 0, and all counts read 0 after release and snap.
